// File: rtl/bcd_7seg_if.sv
// Signal bundle between a display driver and the bcd_7seg decoder.
// The master drives the digit code and controls; the slave returns the registered segment drive.
interface bcd_7seg_if;
  logic [3:0] bcd;
  logic       blank;
  logic       lamp_test;
  logic       dp_in;
  logic [6:0] display;
  logic       dp;
  logic       invalid;

  modport master (
    output bcd, blank, lamp_test, dp_in,
    input  display, dp, invalid
  );

  modport slave (
    input  bcd, blank, lamp_test, dp_in,
    output display, dp, invalid
  );
endinterface

// File: rtl/bcd_7seg.sv
// Registered BCD/hex to 7-segment decoder with lamp test, blanking and decimal point.
// All outputs update one clock after the inputs are sampled.
module bcd_7seg #(
  parameter bit ACTIVE_LOW = 1'b1,
  parameter bit HEX_EN     = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  bcd_7seg_if.slave   bus
);

  logic [6:0] glyph_ag;   // lit set, bit 6 = a ... bit 0 = g
  logic [6:0] lit_ag;
  logic [6:0] lit_idx;    // lit set, bit 0 = a ... bit 6 = g
  logic       dp_lit;
  logic       invalid_d;
  logic [6:0] display_d;
  logic       dp_d;
  logic [6:0] display_q;
  logic       dp_q;
  logic       invalid_q;

  always_comb begin
    glyph_ag  = 7'b0000000;
    invalid_d = 1'b0;
    case (bus.bcd)
      4'd0:  glyph_ag = 7'b1111110;
      4'd1:  glyph_ag = 7'b0110000;
      4'd2:  glyph_ag = 7'b1101101;
      4'd3:  glyph_ag = 7'b1111001;
      4'd4:  glyph_ag = 7'b0110011;
      4'd5:  glyph_ag = 7'b1011011;
      4'd6:  glyph_ag = 7'b1011111;
      4'd7:  glyph_ag = 7'b1110000;
      4'd8:  glyph_ag = 7'b1111111;
      4'd9:  glyph_ag = 7'b1111011;
      4'd10: glyph_ag = HEX_EN ? 7'b1110111 : 7'b0000000;
      4'd11: glyph_ag = HEX_EN ? 7'b0011111 : 7'b0000000;
      4'd12: glyph_ag = HEX_EN ? 7'b1001110 : 7'b0000000;
      4'd13: glyph_ag = HEX_EN ? 7'b0111101 : 7'b0000000;
      4'd14: glyph_ag = HEX_EN ? 7'b1001111 : 7'b0000000;
      default: glyph_ag = HEX_EN ? 7'b1000111 : 7'b0000000;
    endcase
    // invalid tracks the code alone, independent of blank/lamp_test
    if (bus.bcd > 4'd9) begin
      invalid_d = !HEX_EN;
    end
  end

  always_comb begin
    lit_ag = glyph_ag;
    if (bus.lamp_test) begin
      lit_ag = 7'b1111111;
    end else if (bus.blank) begin
      lit_ag = 7'b0000000;
    end
  end

  assign dp_lit = bus.lamp_test | (~bus.blank & bus.dp_in);

  genvar gi;
  generate
    for (gi = 0; gi < 7; gi++) begin : g_seg_order
      assign lit_idx[gi] = lit_ag[6 - gi];
    end
  endgenerate

  assign display_d = lit_idx ^ {7{ACTIVE_LOW}};
  assign dp_d      = dp_lit ^ ACTIVE_LOW;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      display_q <= {7{ACTIVE_LOW}};
      dp_q      <= ACTIVE_LOW;
      invalid_q <= 1'b0;
    end else begin
      display_q <= display_d;
      dp_q      <= dp_d;
      invalid_q <= invalid_d;
    end
  end

  assign bus.display = display_q;
  assign bus.dp      = dp_q;
  assign bus.invalid = invalid_q;

endmodule

// File: tb/tb_bcd_7seg.sv
// Scoreboard bench for bcd_7seg: three parameter variants share one directed stimulus stream,
// expected outputs are queued at issue time and checked by an independent monitor.
module tb_bcd_7seg;

  logic clk;
  logic rst_n;

  bcd_7seg_if if0 ();
  bcd_7seg_if if1 ();
  bcd_7seg_if if2 ();

  // dut 0: defaults, dut 1: hex enabled, dut 2: active-high drive
  bcd_7seg #(.ACTIVE_LOW(1'b1), .HEX_EN(1'b0)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  bcd_7seg #(.ACTIVE_LOW(1'b1), .HEX_EN(1'b1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
  bcd_7seg #(.ACTIVE_LOW(1'b0), .HEX_EN(1'b0)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));

  localparam bit AL_K  [3] = '{1'b1, 1'b1, 1'b0};
  localparam bit HEX_K [3] = '{1'b0, 1'b1, 1'b0};

  typedef struct packed {
    logic [2:0][6:0] disp;
    logic [2:0]      dp;
    logic [2:0]      inv;
  } exp_t;

  exp_t exp_q[$];
  int   pass_cnt  = 0;
  int   total_cnt = 0;

  logic [6:0] disp_a [3];
  logic       dp_a   [3];
  logic       inv_a  [3];
  assign disp_a[0] = if0.display;
  assign disp_a[1] = if1.display;
  assign disp_a[2] = if2.display;
  assign dp_a[0]   = if0.dp;
  assign dp_a[1]   = if1.dp;
  assign dp_a[2]   = if2.dp;
  assign inv_a[0]  = if0.invalid;
  assign inv_a[1]  = if1.invalid;
  assign inv_a[2]  = if2.invalid;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hand-written glyph table, written a..g left to right
  function automatic logic [6:0] glyph(input logic [3:0] code, input bit hex);
    logic [6:0] g;
    case (code)
      4'd0:  g = 7'b1111110;
      4'd1:  g = 7'b0110000;
      4'd2:  g = 7'b1101101;
      4'd3:  g = 7'b1111001;
      4'd4:  g = 7'b0110011;
      4'd5:  g = 7'b1011011;
      4'd6:  g = 7'b1011111;
      4'd7:  g = 7'b1110000;
      4'd8:  g = 7'b1111111;
      4'd9:  g = 7'b1111011;
      4'd10: g = 7'b1110111;
      4'd11: g = 7'b0011111;
      4'd12: g = 7'b1001110;
      4'd13: g = 7'b0111101;
      4'd14: g = 7'b1001111;
      default: g = 7'b1000111;
    endcase
    if (code > 4'd9 && !hex) g = 7'b0000000;
    return g;
  endfunction

  // Map an a..g string (a leftmost) to the display port, where index 0 is a
  function automatic logic [6:0] to_port(input logic [6:0] ag);
    logic [6:0] r;
    for (int i = 0; i < 7; i++) r[i] = ag[6 - i];
    return r;
  endfunction

  task automatic issue(input bit rst, input logic [3:0] code, input bit bl, input bit lt, input bit dpi);
    exp_t       e;
    logic [6:0] lit;
    logic       dpl;
    logic       inv;
    @(negedge clk);
    rst_n         = ~rst;
    if0.bcd       = code; if1.bcd       = code; if2.bcd       = code;
    if0.blank     = bl;   if1.blank     = bl;   if2.blank     = bl;
    if0.lamp_test = lt;   if1.lamp_test = lt;   if2.lamp_test = lt;
    if0.dp_in     = dpi;  if1.dp_in     = dpi;  if2.dp_in     = dpi;
    e = '0;
    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        lit = 7'b0000000;
        dpl = 1'b0;
        inv = 1'b0;
      end else begin
        lit = lt ? 7'b1111111 : (bl ? 7'b0000000 : glyph(code, HEX_K[k]));
        dpl = lt | (!bl & dpi);
        inv = (code > 4'd9) && !HEX_K[k];
      end
      e.disp[k] = AL_K[k] ? ~to_port(lit) : to_port(lit);
      e.dp[k]   = AL_K[k] ? ~dpl : dpl;
      e.inv[k]  = inv;
    end
    exp_q.push_back(e);
  endtask

  // Monitor: outputs are presented every cycle, one expectation per cycle issued
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        for (int k = 0; k < 3; k++) begin
          total_cnt++;
          if (disp_a[k] === e.disp[k]) pass_cnt++;
          else $display("FAIL display dut%0d: got %b need %b", k, disp_a[k], e.disp[k]);
          total_cnt++;
          if (dp_a[k] === e.dp[k]) pass_cnt++;
          else $display("FAIL dp dut%0d: got %b need %b", k, dp_a[k], e.dp[k]);
          total_cnt++;
          if (inv_a[k] === e.inv[k]) pass_cnt++;
          else $display("FAIL invalid dut%0d: got %b need %b", k, inv_a[k], e.inv[k]);
        end
        $display("txn t=%0t disp0=%b dp0=%b inv0=%b disp1=%b inv1=%b disp2=%b dp2=%b",
                 $time, disp_a[0], dp_a[0], inv_a[0], disp_a[1], inv_a[1], disp_a[2], dp_a[2]);
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    if0.bcd = 4'd0; if1.bcd = 4'd0; if2.bcd = 4'd0;
    if0.blank = 1'b0; if1.blank = 1'b0; if2.blank = 1'b0;
    if0.lamp_test = 1'b0; if1.lamp_test = 1'b0; if2.lamp_test = 1'b0;
    if0.dp_in = 1'b0; if1.dp_in = 1'b0; if2.dp_in = 1'b0;

    // reset two cycles with bcd 0, then release
    issue(1'b1, 4'd0, 1'b0, 1'b0, 1'b0);
    issue(1'b1, 4'd0, 1'b0, 1'b0, 1'b0);
    issue(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);

    // full code sweep, one per cycle
    for (int c = 0; c < 16; c++) issue(1'b0, 4'(c), 1'b0, 1'b0, 1'b0);

    // code 12 held: hex vs invalid behaviour, output constant
    issue(1'b0, 4'd12, 1'b0, 1'b0, 1'b0);
    issue(1'b0, 4'd12, 1'b0, 1'b0, 1'b0);

    // priority: lamp_test over blank over decode
    issue(1'b0, 4'd8, 1'b1, 1'b1, 1'b1);
    issue(1'b0, 4'd8, 1'b1, 1'b0, 1'b1);
    issue(1'b0, 4'd8, 1'b0, 1'b0, 1'b1);
    issue(1'b0, 4'd8, 1'b0, 1'b0, 1'b0);

    // invalid still follows the code under lamp_test and blank
    issue(1'b0, 4'd14, 1'b0, 1'b1, 1'b0);
    issue(1'b0, 4'd11, 1'b1, 1'b0, 1'b1);

    // simultaneous change of every input
    issue(1'b0, 4'd3, 1'b0, 1'b0, 1'b1);
    issue(1'b0, 4'd1, 1'b0, 1'b0, 1'b0);

    // mid-operation reset with lamp_test active, then normal restart
    issue(1'b1, 4'd1, 1'b0, 1'b1, 1'b1);
    issue(1'b0, 4'd1, 1'b0, 1'b0, 1'b0);
    issue(1'b0, 4'd7, 1'b0, 1'b0, 1'b1);

    repeat (3) @(negedge clk);
    total_cnt++;
    if (exp_q.size() == 0) pass_cnt++;
    else $display("FAIL drain: got %0d pending need 0", exp_q.size());

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/bcd_7seg.md
BCD_7SEG -- requirements
Module: bcd_7seg

Interface
REQ-001 Parameter ACTIVE_LOW, default 1, segment and dp output polarity: 1 = segment lit when driven 0, 0 = lit when driven 1.
REQ-002 Parameter HEX_EN, default 0, codes 10-15: 1 = decoded as hex glyphs A-F, 0 = treated as invalid.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 bcd  input  4  digit code to display; bit 3 is MSB.
REQ-006 blank  input  1  1 = force all segments and dp off.
REQ-007 lamp_test  input  1  1 = force all segments and dp lit.
REQ-008 dp_in  input  1  1 = light the decimal point.
REQ-009 display  output  7 (indexed 0..6)  segment drive; index 0 = a, 1 = b, 2 = c, 3 = d, 4 = e, 5 = f, 6 = g.
REQ-010 dp  output  1  decimal-point drive, same polarity as display.
REQ-011 invalid  output  1  1 = registered bcd code is not displayable.

Function
REQ-012 display, dp and invalid SHALL be registered outputs with exactly one clock of latency from inputs sampled at a rising edge; no combinational path from input to output.
REQ-013 Lit-segment sets (listed a..g, 1 = lit) SHALL be as follows.
- 0 = 1111110; 1 = 0110000; 2 = 1101101; 3 = 1111001; 4 = 0110011.
- 5 = 1011011; 6 = 1011111; 7 = 1110000; 8 = 1111111; 9 = 1111011.
REQ-014 When HEX_EN = 1, lit sets for codes 10-15 SHALL be as follows.
- A = 1110111; b = 0011111; C = 1001110; d = 0111101; E = 1001111; F = 1000111.
REQ-015 When HEX_EN = 0, codes 10-15 SHALL produce all segments off and set invalid = 1.
REQ-016 invalid SHALL be 0 for codes 0-9, and 0 for all codes when HEX_EN = 1.
REQ-017 invalid SHALL reflect the bcd code regardless of blank and lamp_test.
REQ-018 Output priority, highest first:
- lamp_test: all 7 segments and dp lit.
- blank: all segments and dp off.
- normal decode per REQ-013 to REQ-015; dp lit iff dp_in = 1.
REQ-019 With ACTIVE_LOW = 1, each lit segment SHALL be driven 0 and each unlit segment driven 1; with ACTIVE_LOW = 0, the opposite.
REQ-020 The 4-bit code SHALL be decoded exactly; there is no arithmetic, saturation or wrap.
REQ-021 Inputs SHALL be sampled every cycle; holding an input constant holds the output constant.
REQ-022 Simultaneous change of bcd, blank, lamp_test and dp_in in one cycle SHALL produce the output for the combined new values one cycle later, with no intermediate glyph.

Reset
REQ-023 When rst_n = 0 at a rising edge, on the next output update: display = all segments off, dp = off, invalid = 0.
- With ACTIVE_LOW = 1 this is display = 1111111 and dp = 1.
REQ-024 Reset SHALL have priority over lamp_test, blank and all data inputs.
REQ-025 Asserting reset mid-operation SHALL discard the displayed value.
REQ-026 On the first rising edge with rst_n = 1, inputs SHALL be sampled normally, and the decoded glyph SHALL appear one cycle later.
REQ-027 Before the first reset, output values SHALL be don't-care.

Verification
REQ-028 Defaults; reset held low 2 cycles, then bcd = 0 -> display 1111111 and dp 1 during reset, then display 0000001 (a..g, active-low) one cycle after release.
REQ-029 Defaults; sweep bcd 0-9, one per cycle -> each glyph per REQ-013 (inverted) appears exactly one cycle after its code is applied, invalid = 0 throughout.
REQ-030 HEX_EN = 0; bcd = 12 -> display 1111111, invalid = 1. HEX_EN = 1; bcd = 12 -> display 0110001, invalid = 0.
REQ-031 bcd = 8, dp_in = 1, blank = 1, lamp_test = 1 -> all lit, dp = 0. Drop lamp_test -> all off, dp = 1. Drop blank -> 0000000, dp = 0.
REQ-032 ACTIVE_LOW = 0; bcd = 1 -> display 0110000. Then assert rst_n = 0 while bcd = 1 -> display 0000000 and dp = 0 on the next edge.
